mem_port_arbiter: RTL and testbench

- Memory-side responder for the CPU datapath's two memory ports: port A (instruction fetch) and port B (data load/store).
- Accepts held read/write requests on both ports, arbitrates them onto one physical memory bus, and returns a single-cycle resp with read data to the granted port.
- Sits between cpu_datapath and the physical memory or cache; one transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch A / data B) to single memory bus arbiter; one transaction in flight, alternating priority on contention.
// Grant to strobe 1 cycle, mem_resp to resp_x 1 cycle; requests are held by the CPU and the memory strobe is held until mem_resp.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read_a,
  input  logic                write_a,
  input  logic [DATA_W/8-1:0] wmask_a,
  input  logic [ADDR_W-1:0]   address_a,
  input  logic [DATA_W-1:0]   wdata_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  input  logic                read_b,
  input  logic                write_b,
  input  logic [DATA_W/8-1:0] wmask_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic                gnt_b_q, gnt_b_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_a_q, resp_a_d;
  logic                resp_b_q, resp_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;

  logic                pend_a, pend_b, sel_b, sel_wr;
  logic [DATA_W-1:0]   cap_rdata;

  assign pend_a = read_a | write_a;
  assign pend_b = read_b | write_b;
  // On contention the port that did not win last time goes first.
  assign sel_b  = pend_b & (~pend_a | ~last_b_q);
  assign sel_wr = sel_b ? write_b : write_a;
  // The strobe registers double as the captured op while BUSY.
  assign cap_rdata = mem_write_q ? '0 : mem_rdata;

  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    gnt_b_d       = gnt_b_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_wmask_d   = mem_wmask_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    resp_a_d      = 1'b0;
    resp_b_d      = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;

    case (state_q)
      IDLE: begin
        if (pend_a | pend_b) begin
          gnt_b_d       = sel_b;
          last_b_d      = sel_b;
          mem_write_d   = sel_wr;
          mem_read_d    = ~sel_wr;
          mem_address_d = sel_b ? address_b : address_a;
          mem_wdata_d   = sel_b ? wdata_b : wdata_a;
          mem_wmask_d   = sel_wr ? (sel_b ? wmask_b : wmask_a) : '1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (gnt_b_q) begin
            resp_b_d  = 1'b1;
            rdata_b_d = cap_rdata;
          end else begin
            resp_a_d  = 1'b1;
            rdata_a_d = cap_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_b_q      <= 1'b0;
      gnt_b_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      resp_a_q      <= 1'b0;
      resp_b_q      <= 1'b0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      gnt_b_q       <= gnt_b_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_a_q      <= resp_a_d;
      resp_b_q      <= resp_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_a      = resp_a_q;
  assign resp_b      = resp_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a request-level arbitration model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_a = 1'b0, write_a = 1'b0;
  logic [1:0]  wmask_a = '0;
  logic [15:0] address_a = '0, wdata_a = '0;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b = 1'b0, write_b = 1'b0;
  logic [1:0]  wmask_b = '0;
  logic [15:0] address_b = '0, wdata_b = '0;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_resp_cyc = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
    .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    read_a = 0; write_a = 0; wmask_a = '0; address_a = '0; wdata_a = '0;
    read_b = 0; write_b = 0; wmask_b = '0; address_b = '0; wdata_b = '0;
    mem_resp = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    chk("rst_outs", {resp_a, resp_b, mem_read, mem_write, mem_wmask}, '0);
    chk("rst_data", {rdata_a, rdata_b}, '0);
    chk("rst_bus", {mem_address, mem_wdata}, '0);
    rst_n = 1;
  endtask

  // Called in an IDLE cycle with the request already driven; returns in the IDLE cycle after DONE.
  task automatic serve(input bit gb, input bit wr, input logic [15:0] addr, input logic [1:0] mask,
                       input logic [15:0] wd, input int delay, input logic [15:0] rd, input bit wiggle);
    logic [15:0] other_rd;
    logic [15:0] exp_rd;
    other_rd = gb ? rdata_a : rdata_b;
    exp_rd   = wr ? 16'h0 : rd;
    step();
    chk("strobe_op", {mem_read, mem_write}, {~wr, wr});
    chk("strobe_addr", mem_address, addr);
    chk("strobe_wmask", mem_wmask, wr ? mask : 2'b11);
    if (wr) chk("strobe_wdata", mem_wdata, wd);
    chk("resp_early", {resp_a, resp_b}, 2'b00);
    for (int i = 0; i < delay; i++) begin
      if (wiggle) begin
        if (gb) begin address_b = 16'($urandom); wdata_b = 16'($urandom); end
        else    begin address_a = 16'($urandom); wdata_a = 16'($urandom); end
      end
      step();
      chk("hold_op", {mem_read, mem_write}, {~wr, wr});
      chk("hold_addr", mem_address, addr);
      chk("hold_resp", {resp_a, resp_b}, 2'b00);
    end
    mem_resp = 1;
    mem_rdata = rd;
    step();
    mem_resp = 0;
    mem_rdata = 16'($urandom);
    chk("resp", {resp_a, resp_b}, gb ? 2'b01 : 2'b10);
    chk("rdata", gb ? rdata_b : rdata_a, exp_rd);
    chk("rdata_other", gb ? rdata_a : rdata_b, other_rd);
    chk("strobe_drop", {mem_read, mem_write}, 2'b00);
    last_resp_cyc = cyc;
    step();
    chk("resp_pulse", {resp_a, resp_b}, 2'b00);
    chk("rdata_hold", gb ? rdata_b : rdata_a, exp_rd);
    chk("idle_strobe", {mem_read, mem_write}, 2'b00);
  endtask

  bit          pa, pb, a_wr, b_wr, a_both, b_both, gb, m_last_b;
  logic [15:0] a_addr, b_addr, a_wd, b_wd;
  logic [1:0]  a_mask, b_mask;
  int          first_resp;

  initial begin
    // Reset state
    do_reset();

    // Single read on A, memory answers one cycle after the strobe
    read_a = 1; address_a = 16'h0040;
    serve(1'b0, 1'b0, 16'h0040, 2'b00, 16'h0, 1, 16'h1234, 1'b0);
    read_a = 0;

    // Byte write on B
    write_b = 1; address_b = 16'h8001; wmask_b = 2'b10; wdata_b = 16'hAB00;
    serve(1'b1, 1'b1, 16'h8001, 2'b10, 16'hAB00, 1, 16'h5555, 1'b0);
    write_b = 0;

    // Contention right after reset: B first, then A
    do_reset();
    read_a = 1; address_a = 16'h1111;
    read_b = 1; address_b = 16'h2222;
    serve(1'b1, 1'b0, 16'h2222, 2'b00, 16'h0, 1, 16'hBEEF, 1'b0);
    first_resp = last_resp_cyc;
    read_b = 0;
    serve(1'b0, 1'b0, 16'h1111, 2'b00, 16'h0, 1, 16'hCAFE, 1'b0);
    read_a = 0;
    chk("contention_gap", (last_resp_cyc - first_resp) >= 3, 1);

    // Asynchronous reset in the middle of a transaction
    read_a = 1; address_a = 16'h0ABC;
    step();
    chk("pre_rst_strobe", mem_read, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("async_rst", {mem_read, mem_write, resp_a, resp_b}, 4'b0000);
    read_a = 0;
    step();
    rst_n = 1;
    read_b = 1; address_b = 16'h0777;
    serve(1'b1, 1'b0, 16'h0777, 2'b00, 16'h0, 0, 16'h4321, 1'b0);
    read_b = 0;

    // Stray mem_resp while idle, then a slow memory
    mem_resp = 1; mem_rdata = 16'hDEAD;
    step();
    mem_resp = 0;
    step();
    chk("stray_resp", {resp_a, resp_b, mem_read, mem_write}, 4'b0000);
    read_a = 1; address_a = 16'h3030;
    serve(1'b0, 1'b0, 16'h3030, 2'b00, 16'h0, 10, 16'h6789, 1'b1);
    read_a = 0;

    // Randomized streaming with independent held requests on both ports
    do_reset();
    m_last_b = 0;
    pa = 0; pb = 0;
    a_wr = 0; b_wr = 0; a_both = 0; b_both = 0;
    a_addr = '0; b_addr = '0; a_wd = '0; b_wd = '0; a_mask = '0; b_mask = '0;
    for (int it = 0; it < 80; it++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin
        pa = 1; a_wr = 1'($urandom_range(0, 1)); a_both = 1'($urandom_range(0, 1));
        a_addr = 16'($urandom); a_wd = 16'($urandom); a_mask = 2'($urandom_range(0, 3));
      end
      if (!pb && ($urandom_range(0, 2) != 0)) begin
        pb = 1; b_wr = 1'($urandom_range(0, 1)); b_both = 1'($urandom_range(0, 1));
        b_addr = 16'($urandom); b_wd = 16'($urandom); b_mask = 2'($urandom_range(0, 3));
      end
      if (!pa && !pb) begin
        pa = 1; a_wr = 0; a_both = 0;
        a_addr = 16'($urandom); a_wd = 16'($urandom); a_mask = 2'($urandom_range(0, 3));
      end
      read_a = pa & (~a_wr | a_both); write_a = pa & a_wr;
      address_a = a_addr; wdata_a = a_wd; wmask_a = a_mask;
      read_b = pb & (~b_wr | b_both); write_b = pb & b_wr;
      address_b = b_addr; wdata_b = b_wd; wmask_b = b_mask;
      gb = pb && (!pa || !m_last_b);
      m_last_b = gb;
      if (gb)
        serve(1'b1, b_wr, b_addr, b_mask, b_wd, $urandom_range(0, 3), 16'($urandom), 1'b1);
      else
        serve(1'b0, a_wr, a_addr, a_mask, a_wd, $urandom_range(0, 3), 16'($urandom), 1'b1);
      if (gb) pb = 0; else pa = 0;
    end
    clear_inputs();
    step();
    chk("final_idle", {resp_a, resp_b, mem_read, mem_write}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
